mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the multicycle RISC-V core's unified instruction/data memory port. Accepts one fetch, load or store request at a time over a valid/ready handshake, inserts a programmable number of wait states, performs the word access on an internal array, and returns read data or an error over a second valid/ready channel. It replaces the zero-latency combinational memory behind the controller's `adrsrc`/`memwrite`/`irwrite` path, so the controller FSM can stall in FETCH/MEMREAD/MEMWRITE until `rsp_valid`.

## Interface
- `DEPTH_WORDS`, default 64: number of 32-bit words. Power of two, ≥ 4.
- `WAIT_CYCLES`, default 2: wait states inserted per access. Range 0..15.
- `clk` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request.
- `req_we` in 1: 1 means store, 0 means fetch/load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: requester takes the response.
- `rsp_rdata` out 32: read data. Always 0 for stores and errors.
- `rsp_err` out 1: misaligned or out-of-range access.

## Operation
- FSM states:
  - IDLE: `req_ready` = 1.
  - WAIT: wait-state countdown.
  - RESP: `rsp_valid` = 1.
- IDLE transitions:
  - On `req_valid` and `req_ready` at an edge (the accept edge), latch `req_we`, `req_addr` and `req_wdata`.
  - If `WAIT_CYCLES` = 0, go directly to RESP.
  - Otherwise go to WAIT with `wait_cnt` = `WAIT_CYCLES` − 1.
- WAIT transitions:
  - Decrement `wait_cnt` each cycle.
  - When `wait_cnt` = 0, go to RESP.
- Access is performed on the edge that enters RESP:
  - Error check: `addr[1:0]` ≠ 0, or `addr` ≥ `DEPTH_WORDS`·4. On error: no array access, `rsp_err` = 1, `rsp_rdata` = 0.
  - Store: write `wdata` to word `addr[log2(DEPTH_WORDS)+1:2]`. `rsp_rdata` = 0.
  - Load/fetch: register the array word into `rsp_rdata`.
- RESP transitions:
  - Hold `rsp_valid`, `rsp_rdata` and `rsp_err` stable until `rsp_valid` and `rsp_ready` at an edge, then go to IDLE.
  - Register `rsp_rdata` and `rsp_err` are cleared to 0 on that edge.
- Requests presented while `req_ready` = 0 are ignored. There is no buffering, and the requester holds `req_valid`.
- Array contents are not reset and persist across `reset`.

## Timing
- Reset values:
  - State: IDLE.
  - `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, `wait_cnt` = 0.
- Latency: `rsp_valid` rises exactly `WAIT_CYCLES` + 1 edges after the accept edge. With `WAIT_CYCLES` = 0, it is high in the cycle immediately after the accept edge.
- Throughput: at most one request per `WAIT_CYCLES` + 2 cycles.
  - `req_ready` returns high in the cycle after the completing response edge.
  - A request and a response never complete on the same edge.
- Backpressure: if `rsp_ready` = 0, RESP is held indefinitely with outputs stable.
- Reset mid-operation:
  - In WAIT: the pending store is dropped and the array is unchanged.
  - In RESP: the response is discarded, but a store committed on RESP entry stays committed.
- Last word (`DEPTH_WORDS`·4 − 4) is valid. `DEPTH_WORDS`·4 is an error. There is no address wrap-around.
- Reset asserted together with `req_valid` on the same edge: the request is not accepted.

## Structure
- Package `mem_pkg` holds:
  - `mem_state_t` enum {IDLE, WAIT, RESP}, 2 bits.
  - Constant `WORD_BYTES` = 4.
  - Function `addr_ok(addr, depth)`.
- Sub-module `mem_array`: single port, `DEPTH_WORDS` × 32, synchronous write enable, combinational read.
  - `mem_responder` registers the read output.
- `aludec`-style gate netlists are not used. The FSM is one `always_ff` state register plus one `always_comb` next-state/output block.

## Test plan
- Store 0xDEADBEEF to 0x10, then load 0x10 with `WAIT_CYCLES` = 2:
  - Each `rsp_valid` occurs 3 edges after its accept.
  - Load returns 0xDEADBEEF with `rsp_err` = 0.
- `WAIT_CYCLES` = 0, back-to-back loads of 0x0 and 0x4 with `rsp_ready` tied high:
  - `rsp_valid` is high 1 cycle after each accept.
  - Second accept occurs 2 cycles after the first.
- Load 0x12 (misaligned) and load 0x100 with `DEPTH_WORDS` = 64:
  - Both return `rsp_err` = 1 and `rsp_rdata` = 0.
  - Store to 0x100 leaves word 0 unchanged.
- Hold `rsp_ready` = 0 for 5 cycles in RESP:
  - `rsp_valid`, `rsp_rdata` and `rsp_err` stay constant.
  - `req_ready` stays 0 and a new `req_valid` is ignored.
- Assert `reset` during WAIT of a store of 0x12345678 to 0x8 (prior content 0xAAAA5555):
  - Outputs return to reset values next cycle.
  - A subsequent load of 0x8 returns 0xAAAA5555.
- Store to 0xFC, then load 0xFC (last word, `DEPTH_WORDS` = 64):
  - Data matches and `rsp_err` = 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam int unsigned WORD_BYTES = 4;

  // Word-aligned and inside the array; addresses never wrap.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && (addr < 32'(depth * WORD_BYTES));
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word array: synchronous write, combinational read. Contents are not reset.
module mem_array #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, programmable wait states, registered response.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES - 1);

  mem_state_t  state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        enter_resp;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_ok;
  logic        arr_we;
  logic [31:0] arr_rdata;

  // State and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Next-state, access decode and handshake outputs
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;

    req_ready  = (state_q == IDLE);
    rsp_valid  = (state_q == RESP);

    // With zero wait states the access happens on the accept edge, so it must
    // use the live request rather than the not-yet-latched copy.
    if (state_q == IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
    acc_ok = addr_ok(acc_addr, DEPTH_WORDS);

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d    = WAIT;
            wait_cnt_d = WaitInit;
          end
        end
      end
      WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (enter_resp) begin
      err_d   = ~acc_ok;
      rdata_d = (!acc_we && acc_ok) ? arr_rdata : 32'd0;
    end

    // A reset on the commit edge must not let the store reach the array.
    arr_we = enter_resp && acc_we && acc_ok && !reset;
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (AW)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .addr (acc_addr[AW+1:2]),
    .wdata(acc_wdata),
    .rdata(arr_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: random and directed traffic against a word-array model.
module tb_mem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned W     = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // Zero-wait-state instance for the back-to-back throughput check
  logic        z_req_valid, z_req_ready, z_req_we;
  logic [31:0] z_req_addr, z_req_wdata;
  logic        z_rsp_valid, z_rsp_ready;
  logic [31:0] z_rsp_rdata;
  logic        z_rsp_err;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  logic hold_mode = 1'b0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mdl[DEPTH];

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk      (clk),
    .reset    (reset),
    .req_valid(z_req_valid),
    .req_ready(z_req_ready),
    .req_we   (z_req_we),
    .req_addr (z_req_addr),
    .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid),
    .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata),
    .rsp_err  (z_rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response backpressure: random unless a test holds it low
  always begin
    @(posedge clk);
    #1;
    rsp_ready = hold_mode ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: pop one expectation per response, then check it stays stable
  exp_t cur;
  logic shown = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      shown = 1'b0;
    end else if (rsp_valid) begin
      chk("req_ready_low_in_resp", {31'd0, req_ready}, 32'd0);
      if (!shown) begin
        if (sbq.size() == 0) begin
          chk("unexpected_response", 32'd1, 32'd0);
        end else begin
          cur = sbq.pop_front();
          chk("rsp_rdata", rsp_rdata, cur.rdata);
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, cur.err});
          // edges from the accept edge to the RESP-entry edge, both counted
          chk("latency_edges", 32'(cyc - cur.acc + 1), 32'(W + 1));
          if (cur.we && !cur.err) mdl[cur.addr[7:2]] = cur.wdata;
        end
        shown = 1'b1;
      end else begin
        chk("rsp_rdata_stable", rsp_rdata, cur.rdata);
        chk("rsp_err_stable", {31'd0, rsp_err}, {31'd0, cur.err});
      end
    end else begin
      shown = 1'b0;
    end
  end

  // Issue one request; returns just after the accept edge.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    logic ok;
    int   n = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 100) begin
        chk("accept_timeout", 32'd1, 32'd0);
        req_valid = 1'b0;
        return;
      end
    end
    ok       = (addr % 4 == 0) && (addr < DEPTH * 4);
    e.we     = we;
    e.addr   = addr;
    e.wdata  = wdata;
    e.err    = !ok;
    e.rdata  = (!we && ok) ? mdl[addr / 4] : 32'd0;
    e.acc    = cyc + 1;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 || rsp_valid) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        chk("drain_timeout", 32'(sbq.size()), 32'd0);
        sbq.delete();
        return;
      end
    end
  endtask

  task automatic wait_z_ready(output int acc);
    int n = 0;
    acc = -1;
    forever begin
      @(negedge clk);
      if (z_req_ready) begin
        acc = cyc + 1;
        return;
      end
      n++;
      if (n > 50) begin
        chk("z_accept_timeout", 32'd1, 32'd0);
        return;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int a1, a2, n;
    logic [31:0] addr;
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_we      = 1'b0;
    req_addr    = 32'd0;
    req_wdata   = 32'd0;
    rsp_ready   = 1'b1;
    z_req_valid = 1'b0;
    z_req_we    = 1'b0;
    z_req_addr  = 32'd0;
    z_req_wdata = 32'd0;
    z_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);

    // Give every word a known value
    for (int i = 0; i < int'(DEPTH); i++) do_req(1'b1, 32'(i * 4), $urandom);
    drain();

    // Store then load
    do_req(1'b1, 32'h10, 32'hDEADBEEF);
    do_req(1'b0, 32'h10, 32'd0);
    drain();

    // Error cases; a failed store must leave word 0 alone
    do_req(1'b0, 32'h12, 32'd0);
    do_req(1'b0, 32'h100, 32'd0);
    do_req(1'b1, 32'h100, 32'h0BADF00D);
    do_req(1'b0, 32'h0, 32'd0);
    drain();

    // Backpressure: RESP held 5 cycles while a new request is presented
    hold_mode = 1'b1;
    do_req(1'b0, 32'h10, 32'd0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_rsp_reached", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    hold_mode = 1'b0;
    drain();

    // Reset during WAIT drops the pending store
    do_req(1'b1, 32'h8, 32'hAAAA5555);
    drain();
    do_req(1'b1, 32'h8, 32'h12345678);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("midreset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midreset_rsp_rdata", rsp_rdata, 32'd0);
    chk("midreset_rsp_err", {31'd0, rsp_err}, 32'd0);
    do_req(1'b0, 32'h8, 32'd0);
    drain();

    // Last word
    do_req(1'b1, 32'hFC, 32'hC0FFEE01);
    do_req(1'b0, 32'hFC, 32'd0);
    drain();

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      addr = 32'($urandom_range(0, 69) * 4);
      if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
      do_req(1'($urandom_range(0, 1)), addr, $urandom);
    end
    drain();

    // Zero wait states: prime words 0 and 4, then back-to-back loads
    z_rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      z_req_valid = 1'b1;
      z_req_we    = 1'b1;
      z_req_addr  = 32'(i * 4);
      z_req_wdata = (i == 0) ? 32'h11111111 : 32'h22222222;
      wait_z_ready(a1);
      @(posedge clk);
      #1;
      z_req_valid = 1'b0;
      repeat (2) @(posedge clk);
    end
    @(posedge clk);
    #1;
    z_req_valid = 1'b1;
    z_req_we    = 1'b0;
    z_req_addr  = 32'h0;
    wait_z_ready(a1);
    @(posedge clk);
    #1;
    z_req_addr = 32'h4;
    @(negedge clk);
    chk("z_rsp_valid_1", {31'd0, z_rsp_valid}, 32'd1);
    chk("z_rsp_rdata_1", z_rsp_rdata, 32'h11111111);
    chk("z_rsp_err_1", {31'd0, z_rsp_err}, 32'd0);
    chk("z_req_ready_busy", {31'd0, z_req_ready}, 32'd0);
    wait_z_ready(a2);
    chk("z_accept_spacing", 32'(a2 - a1), 32'd2);
    @(posedge clk);
    #1;
    z_req_valid = 1'b0;
    @(negedge clk);
    chk("z_rsp_valid_2", {31'd0, z_rsp_valid}, 32'd1);
    chk("z_rsp_rdata_2", z_rsp_rdata, 32'h22222222);
    @(negedge clk);
    chk("z_rsp_done", {31'd0, z_rsp_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
